puf_chal_resp_seq: RTL

Parametrised challenge-assembly and evaluation sequencer between the PicoBlaze PUF controller and an N-bit, K-output PUF core (APUF/XAPUF family). Challenge words arrive as 64-bit slices with a word index, are assembled into an N-bit register, and a trigger pulse launches the PUF. The response vector is then captured with timeout protection. Optionally, the PUF is evaluated REPS times and a per-bit majority is returned, so noisy responses are stabilised in hardware rather than on the PC.

---
 rtl/puf_seq_pkg.sv | 29 ++
 rtl/puf_maj_vote.sv | 49 ++++
 rtl/puf_chal_resp_seq.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/puf_seq_pkg.sv
// Shared definitions for the PUF challenge/response sequencer:
// sequencer state encoding, a constant-foldable ceil(log2) helper and the
// challenge word width.
package puf_seq_pkg;

    localparam int WORD_W = 64;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FIRE  = 3'd1,
        WAIT  = 3'd2,
        REARM = 3'd3,
        DONE  = 3'd4
    } state_e;

    // ceil(log2(value)); returns 0 for value <= 1
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/puf_maj_vote.sv
// Per-bit majority voter: K saturating vote counters with synchronous clear
// and accumulate enable. maj_o[i] is high when more than half of REPS
// evaluations returned 1 on bit i. Instantiated only under PUF_MAJ_VOTE_EN.
module puf_maj_vote
    import puf_seq_pkg::*;
#(
    parameter int K    = 6,
    parameter int REPS = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         acc_i,
    input  logic [K-1:0] bits_i,
    output logic [K-1:0] maj_o
);

    localparam int CW = (clog2(REPS + 1) < 1) ? 1 : clog2(REPS + 1);

    logic [CW-1:0] cnt_q [K];
    logic [CW-1:0] cnt_d [K];

    // next count per bit (clear wins, saturate at REPS) and majority decision
    always_comb begin
        for (int i = 0; i < K; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clr_i) begin
                cnt_d[i] = '0;
            end else if (acc_i && bits_i[i] && (cnt_q[i] != CW'(REPS))) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
            maj_o[i] = (cnt_q[i] > CW'(REPS / 2));
        end
    end

    // vote counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < K; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < K; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: rtl/puf_chal_resp_seq.sv
// Challenge assembly and evaluation sequencer for an N-bit, K-output PUF.
// Challenge words are written only while idle; start launches FIRE -> WAIT ->
// REARM (repeated per evaluation) -> DONE, with a TMO-cycle timeout in each
// wait state. Define PUF_MAJ_VOTE_EN to evaluate REPS times and return the
// per-bit majority; otherwise a single evaluation is captured.
// Handshake: puf_ready is a level sampled on the same clock; a response is
// taken on the first cycle in WAIT with puf_ready high, and the PUF must drop
// puf_ready again (seen in REARM) before the next launch or DONE.
module puf_chal_resp_seq
    import puf_seq_pkg::*;
#(
    parameter int  N      = 128,
    parameter int  K      = 6,
    parameter int  TRIG_W = 4,
    parameter int  TMO    = 1023,
    parameter int  REPS   = 5,
    localparam int NW     = N / WORD_W,
    localparam int IDXW   = (clog2(NW) < 1) ? 1 : clog2(NW)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            wr_en,
    input  logic [IDXW-1:0] wr_idx,
    input  logic [63:0]     wr_data,
    input  logic            start,
    output logic [N-1:0]    challenge,
    output logic            trig,
    input  logic            puf_ready,
    input  logic [K-1:0]    puf_resp,
    output logic [K-1:0]    resp,
    output logic            resp_valid,
    output logic            busy,
    output logic            err,
    output state_e          dbg_state_o
);

`ifdef PUF_MAJ_VOTE_EN
    localparam int REPS_EFF = REPS;
`else
    localparam int REPS_EFF = 1;
`endif

    localparam int CNT_MAX = (TMO > TRIG_W) ? TMO : TRIG_W;
    localparam int CNT_W   = (clog2(CNT_MAX + 1) < 1) ? 1 : clog2(CNT_MAX + 1);
    localparam int RW      = (clog2(REPS + 1) < 1) ? 1 : clog2(REPS + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RW-1:0]    reps_q, reps_d;
    logic [N-1:0]     challenge_q, challenge_d;
    logic [K-1:0]     resp_q, resp_d;
    logic             err_q, err_d;
    logic             vote_clr, vote_acc;
    logic [K-1:0]     eval_resp;

`ifdef PUF_MAJ_VOTE_EN
    puf_maj_vote #(
        .K    (K),
        .REPS (REPS)
    ) u_vote (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (vote_clr),
        .acc_i  (vote_acc),
        .bits_i (puf_resp),
        .maj_o  (eval_resp)
    );
`else
    logic [K-1:0] cap_q;

    // single-shot capture of the PUF response taken in WAIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_q <= '0;
        end else if (vote_acc) begin
            cap_q <= puf_resp;
        end
    end

    assign eval_resp = cap_q;
`endif

    // next-state, counters, challenge writes and result update
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        reps_d      = reps_q;
        challenge_d = challenge_q;
        resp_d      = resp_q;
        err_d       = err_q;
        vote_clr    = 1'b0;
        vote_acc    = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    challenge_d = '0;
                end else if (wr_en) begin
                    for (int w = 0; w < NW; w++) begin
                        if (wr_idx == IDXW'(w)) begin
                            challenge_d[w*WORD_W +: WORD_W] = wr_data;
                        end
                    end
                end
                if (start) begin
                    state_d  = FIRE;
                    cnt_d    = '0;
                    reps_d   = '0;
                    err_d    = 1'b0;
                    vote_clr = 1'b1;
                end
            end
            FIRE: begin
                if (cnt_q == CNT_W'(TRIG_W - 1)) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT: begin
                if (puf_ready) begin
                    vote_acc = 1'b1;
                    reps_d   = reps_q + RW'(1);
                    state_d  = REARM;
                    cnt_d    = '0;
                end else if (cnt_q == CNT_W'(TMO)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    resp_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REARM: begin
                if (!puf_ready) begin
                    cnt_d = '0;
                    if (reps_q == RW'(REPS_EFF)) begin
                        state_d = DONE;
                        resp_d  = eval_resp;
                    end else begin
                        state_d = FIRE;
                    end
                end else if (cnt_q == CNT_W'(TMO)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    resp_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // sequencer and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            reps_q      <= '0;
            challenge_q <= '0;
            resp_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            reps_q      <= reps_d;
            challenge_q <= challenge_d;
            resp_q      <= resp_d;
            err_q       <= err_d;
        end
    end

    assign challenge   = challenge_q;
    assign trig        = (state_q == FIRE);
    assign busy        = (state_q == FIRE) || (state_q == WAIT) || (state_q == REARM);
    assign resp_valid  = (state_q == DONE);
    assign resp        = resp_q;
    assign err         = err_q;
    assign dbg_state_o = state_q;

endmodule
